// File: rtl/ahb_protocol_checker.sv
// ahb_protocol_checker: passive AHB slave-port monitor. It evaluates eight
// protocol/decode checks each cycle, follows burst progress with a small FSM,
// and keeps saturating pass/fail counters per check behind a select mux.
//
// Handshake: an address phase is accepted when HREADY=1 and HTRANS is NONSEQ
// or SEQ. Its data phase completes at the first later cycle with HREADY=1.
// An ERROR response is two cycles long (HREADY=0/HRESP=1 then HREADY=1/HRESP=1).
// The first cycle is remembered and the check is resolved on the second.
module ahb_protocol_checker #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int NUM_SLAVES      = 2,
    parameter int SLAVE_SIZE_LOG2 = 10,
    parameter int RO_BYTES        = 4,
    parameter int CNT_W           = 16
) (
    input  logic              HCLK,
    input  logic              reset,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [2:0]        HBURST,
    input  logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    input  logic              HRESP,
    input  logic              clr,
    input  logic [2:0]        cnt_sel,
    output logic [CNT_W-1:0]  cnt_pass,
    output logic [CNT_W-1:0]  cnt_fail,
    output logic [7:0]        fail_pulse,
    output logic [7:0]        sticky_fail,
    output logic              burst_state_dbg
);

    typedef enum logic {B_IDLE = 1'b0, B_ACT = 1'b1} bstate_t;

    localparam logic [1:0]        T_IDLE   = 2'd0;
    localparam logic [1:0]        T_BUSY   = 2'd1;
    localparam logic [1:0]        T_NONSEQ = 2'd2;
    localparam logic [1:0]        T_SEQ    = 2'd3;
    localparam logic [ADDR_W:0]   LIMIT    = (ADDR_W+1)'(NUM_SLAVES) << SLAVE_SIZE_LOG2;
    localparam logic [ADDR_W-1:0] OFF_MASK = (ADDR_W'(1) << SLAVE_SIZE_LOG2) - ADDR_W'(1);

    // Beat count of a fixed-length burst; zero for SINGLE/INCR.
    function automatic logic [4:0] beats_n(input logic [2:0] b);
        case (b[2:1])
            2'd1:    beats_n = 5'd4;
            2'd2:    beats_n = 5'd8;
            2'd3:    beats_n = 5'd16;
            default: beats_n = 5'd0;
        endcase
    endfunction

    bstate_t           state_q, state_d;
    logic [4:0]        beat_q, beat_d;
    logic [ADDR_W-1:0] prev_addr_q, prev_addr_d;
    logic [ADDR_W-1:0] wrap_mask_q, wrap_mask_d;
    logic [2:0]        burst_q, burst_d;
    logic              burst_err_q, burst_err_d;
    logic              dp_valid_q, dp_valid_d;
    logic              dp_write_q, dp_write_d;
    logic              dp_oor_q, dp_oor_d;
    logic              dp_ro_q, dp_ro_d;
    logic              err_seen_q, err_seen_d;
    logic              idle_dp_q, idle_dp_d;
    logic              prev_valid_q;
    logic              stall_ap_q, stall_ap_d;
    logic              stall_wd_q, stall_wd_d;
    logic [ADDR_W-1:0] haddr_q;
    logic              hwrite_q;
    logic [2:0]        hsize_q, hburst_q;
    logic [1:0]        htrans_q;
    logic [DATA_W-1:0] hwdata_q;
    logic [CNT_W-1:0]  pass_q [8];
    logic [CNT_W-1:0]  pass_d [8];
    logic [CNT_W-1:0]  fail_q [8];
    logic [CNT_W-1:0]  fail_d [8];
    logic [7:0]        pulse_q, pulse_d;
    logic [7:0]        sticky_q, sticky_d;

    logic [7:0]        ant, ok, pass_vec, fail_vec;
    logic              accept, done, err_now, fixed, ctrl_moved;
    logic [ADDR_W-1:0] inc, exp_seq;

    // Check evaluation, burst FSM next state, data-phase tracking and counters.
    always_comb begin
        accept     = HREADY && HTRANS[1];
        done       = dp_valid_q && HREADY;
        err_now    = HRESP || err_seen_q;
        fixed      = (burst_q[2:1] != 2'd0);
        inc        = ADDR_W'(1) << HSIZE;
        exp_seq    = (prev_addr_q & ~wrap_mask_q) | ((prev_addr_q + inc) & wrap_mask_q);
        ctrl_moved = (HADDR != haddr_q) || (HWRITE != hwrite_q) || (HSIZE != hsize_q) ||
                     (HBURST != hburst_q) || (HTRANS != htrans_q);

        ant = '0;
        ok  = '0;
        ant[0] = done && dp_oor_q;
        ok[0]  = err_now;
        ant[1] = done && dp_ro_q && !dp_oor_q;
        ok[1]  = err_now;
        ant[2] = done && !(dp_oor_q || dp_ro_q);
        ok[2]  = !err_now;
        ant[3] = prev_valid_q && (stall_ap_q || stall_wd_q);
        ok[3]  = !(stall_ap_q && ctrl_moved) && !(stall_wd_q && (HWDATA != hwdata_q));
        ant[4] = idle_dp_q;
        ok[4]  = HREADY && !HRESP;
        ant[6] = prev_valid_q && accept && HTRANS[0] && (state_q == B_ACT);
        ok[6]  = (HADDR == exp_seq);
        ant[7] = HREADY && HTRANS[0];
        ok[7]  = (state_q == B_ACT);

        state_d     = state_q;
        beat_d      = beat_q;
        prev_addr_d = prev_addr_q;
        wrap_mask_d = wrap_mask_q;
        burst_d     = burst_q;
        burst_err_d = burst_err_q || ((state_q == B_ACT) && HRESP);
        if (HREADY) begin
            case (HTRANS)
                T_NONSEQ: begin
                    if (state_q == B_ACT && fixed) begin
                        ant[5] = 1'b1;
                        ok[5]  = burst_err_q || HRESP;
                    end
                    if (HBURST != 3'd0) begin
                        state_d     = B_ACT;
                        beat_d      = 5'd1;
                        prev_addr_d = HADDR;
                        burst_d     = HBURST;
                        burst_err_d = 1'b0;
                        wrap_mask_d = HBURST[0] ? '1 :
                                      ((ADDR_W'(beats_n(HBURST)) << HSIZE) - ADDR_W'(1));
                    end else begin
                        state_d = B_IDLE;
                    end
                end
                T_SEQ: begin
                    if (state_q == B_ACT) begin
                        beat_d      = beat_q + 5'd1;
                        prev_addr_d = HADDR;
                        if (fixed && (beat_q + 5'd1 == beats_n(burst_q))) begin
                            ant[5]  = 1'b1;
                            ok[5]   = 1'b1;
                            state_d = B_IDLE;
                        end
                    end
                end
                T_IDLE: begin
                    if (state_q == B_ACT && fixed) begin
                        ant[5] = 1'b1;
                        ok[5]  = burst_err_q || HRESP;
                    end
                    state_d = B_IDLE;
                end
                T_BUSY: begin
                    state_d = state_q;
                end
                default: state_d = state_q;
            endcase
        end

        pass_vec = ant & ok;
        fail_vec = ant & ~ok;

        dp_valid_d = dp_valid_q;
        dp_write_d = dp_write_q;
        dp_oor_d   = dp_oor_q;
        dp_ro_d    = dp_ro_q;
        err_seen_d = err_seen_q || (dp_valid_q && !HREADY && HRESP);
        if (done) begin
            dp_valid_d = 1'b0;
            err_seen_d = 1'b0;
        end
        if (accept) begin
            dp_valid_d = 1'b1;
            dp_write_d = HWRITE;
            dp_oor_d   = ({1'b0, HADDR} >= LIMIT);
            dp_ro_d    = HWRITE && ((HADDR & OFF_MASK) < ADDR_W'(RO_BYTES));
        end
        idle_dp_d  = HREADY && !HTRANS[1];
        stall_ap_d = !HREADY && HTRANS[1];
        stall_wd_d = dp_valid_q && dp_write_q && !HREADY;

        for (int i = 0; i < 8; i++) begin
            pass_d[i] = pass_q[i];
            fail_d[i] = fail_q[i];
            if (clr) begin
                pass_d[i] = '0;
                fail_d[i] = '0;
            end else begin
                if (pass_vec[i] && (pass_q[i] != '1)) pass_d[i] = pass_q[i] + CNT_W'(1);
                if (fail_vec[i] && (fail_q[i] != '1)) fail_d[i] = fail_q[i] + CNT_W'(1);
            end
        end
        pulse_d  = fail_vec;
        sticky_d = clr ? 8'd0 : (sticky_q | fail_vec);
    end

    // State register for the whole checker; reset abandons any burst or data phase.
    always_ff @(posedge HCLK or negedge reset) begin
        if (!reset) begin
            state_q      <= B_IDLE;
            beat_q       <= '0;
            prev_addr_q  <= '0;
            wrap_mask_q  <= '1;
            burst_q      <= '0;
            burst_err_q  <= 1'b0;
            dp_valid_q   <= 1'b0;
            dp_write_q   <= 1'b0;
            dp_oor_q     <= 1'b0;
            dp_ro_q      <= 1'b0;
            err_seen_q   <= 1'b0;
            idle_dp_q    <= 1'b0;
            prev_valid_q <= 1'b0;
            stall_ap_q   <= 1'b0;
            stall_wd_q   <= 1'b0;
            haddr_q      <= '0;
            hwrite_q     <= 1'b0;
            hsize_q      <= '0;
            hburst_q     <= '0;
            htrans_q     <= '0;
            hwdata_q     <= '0;
            pulse_q      <= '0;
            sticky_q     <= '0;
            for (int i = 0; i < 8; i++) begin
                pass_q[i] <= '0;
                fail_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            prev_addr_q  <= prev_addr_d;
            wrap_mask_q  <= wrap_mask_d;
            burst_q      <= burst_d;
            burst_err_q  <= burst_err_d;
            dp_valid_q   <= dp_valid_d;
            dp_write_q   <= dp_write_d;
            dp_oor_q     <= dp_oor_d;
            dp_ro_q      <= dp_ro_d;
            err_seen_q   <= err_seen_d;
            idle_dp_q    <= idle_dp_d;
            prev_valid_q <= 1'b1;
            stall_ap_q   <= stall_ap_d;
            stall_wd_q   <= stall_wd_d;
            haddr_q      <= HADDR;
            hwrite_q     <= HWRITE;
            hsize_q      <= HSIZE;
            hburst_q     <= HBURST;
            htrans_q     <= HTRANS;
            hwdata_q     <= HWDATA;
            pulse_q      <= pulse_d;
            sticky_q     <= sticky_d;
            for (int i = 0; i < 8; i++) begin
                pass_q[i] <= pass_d[i];
                fail_q[i] <= fail_d[i];
            end
        end
    end

    assign cnt_pass        = pass_q[cnt_sel];
    assign cnt_fail        = fail_q[cnt_sel];
    assign fail_pulse      = pulse_q;
    assign sticky_fail     = sticky_q;
    assign burst_state_dbg = (state_q == B_ACT);

endmodule

// File: tb/tb_ahb_protocol_checker.sv
// Directed bench for ahb_protocol_checker: each scenario clears the counters,
// drives a hand-built bus sequence and compares counters against hand totals.
module tb_ahb_protocol_checker;

    localparam logic [1:0] T_IDLE   = 2'd0;
    localparam logic [1:0] T_BUSY   = 2'd1;
    localparam logic [1:0] T_NONSEQ = 2'd2;
    localparam logic [1:0] T_SEQ    = 2'd3;

    logic        HCLK = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] HADDR = '0;
    logic [1:0]  HTRANS = T_IDLE;
    logic        HWRITE = 1'b0;
    logic [2:0]  HSIZE = 3'd2;
    logic [2:0]  HBURST = 3'd0;
    logic [31:0] HWDATA = '0;
    logic        HREADY = 1'b1;
    logic        HRESP = 1'b0;
    logic        clr = 1'b0;
    logic [2:0]  cnt_sel = '0;
    logic [15:0] cnt_pass, cnt_fail;
    logic [7:0]  fail_pulse, sticky_fail;
    logic        burst_state_dbg;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_p [8];
    int exp_f [8];
    logic [31:0] wrap_seq [8];

    ahb_protocol_checker dut (
        .HCLK(HCLK), .reset(reset), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP),
        .clr(clr), .cnt_sel(cnt_sel), .cnt_pass(cnt_pass), .cnt_fail(cnt_fail),
        .fail_pulse(fail_pulse), .sticky_fail(sticky_fail), .burst_state_dbg(burst_state_dbg)
    );

    // Clock/reset block
    always #20 HCLK = ~HCLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // Driver: present one bus cycle, let the DUT sample it, return 1ns after the edge.
    task automatic drive(input logic [1:0] tr, input logic [31:0] ad, input logic wr,
                         input logic [2:0] bu, input logic rdy, input logic rsp,
                         input logic [31:0] wd);
        HTRANS = tr; HADDR = ad; HWRITE = wr; HBURST = bu;
        HREADY = rdy; HRESP = rsp; HWDATA = wd;
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle();
        drive(T_IDLE, 32'h0, 1'b0, 3'd0, 1'b1, 1'b0, HWDATA);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        idle();
        clr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_p[i] = 0;
            exp_f[i] = 0;
        end
    endtask

    // Reads every counter (8ns total, finishes before the next edge).
    task automatic check_cnts(input string tag, input bit skip4);
        for (int i = 0; i < 8; i++) begin
            if (i != 4 || !skip4) begin
                cnt_sel = 3'(i);
                #1;
                check_eq($sformatf("%s_pass%0d", tag, i), 32'(cnt_pass), 32'(exp_p[i]));
                check_eq($sformatf("%s_fail%0d", tag, i), 32'(cnt_fail), 32'(exp_f[i]));
            end
        end
    endtask

    task automatic incr4(input logic [31:0] last_addr);
        drive(T_NONSEQ, 32'h100, 1'b0, 3'd3, 1'b1, 1'b0, 32'h0);
        check_eq("incr4_fsm_act", 32'(burst_state_dbg), 32'd1);
        drive(T_SEQ,  32'h104, 1'b0, 3'd3, 1'b1, 1'b0, 32'h0);
        drive(T_BUSY, 32'h108, 1'b0, 3'd3, 1'b1, 1'b0, 32'h0);
        drive(T_SEQ,  32'h108, 1'b0, 3'd3, 1'b1, 1'b0, 32'h0);
        drive(T_SEQ,  last_addr, 1'b0, 3'd3, 1'b1, 1'b0, 32'h0);
        idle();
        check_eq("incr4_fsm_idle", 32'(burst_state_dbg), 32'd0);
    endtask

    initial begin
        wrap_seq[0] = 32'h118; wrap_seq[1] = 32'h11C; wrap_seq[2] = 32'h100; wrap_seq[3] = 32'h104;
        wrap_seq[4] = 32'h108; wrap_seq[5] = 32'h10C; wrap_seq[6] = 32'h110; wrap_seq[7] = 32'h114;
        for (int i = 0; i < 8; i++) begin
            exp_p[i] = 0;
            exp_f[i] = 0;
        end

        // Reset state
        repeat (2) @(posedge HCLK);
        #1;
        check_cnts("reset", 1'b0);
        check_eq("reset_pulse", 32'(fail_pulse), 32'd0);
        check_eq("reset_sticky", 32'(sticky_fail), 32'd0);
        check_eq("reset_fsm", 32'(burst_state_dbg), 32'd0);
        reset = 1'b1;
        repeat (2) idle();

        // Single OKAY write to 0x10
        do_clr();
        drive(T_NONSEQ, 32'h10, 1'b1, 3'd0, 1'b1, 1'b0, 32'h0);
        drive(T_IDLE, 32'h0, 1'b0, 3'd0, 1'b1, 1'b0, $urandom);
        exp_p[2] = 1;
        check_cnts("wr_ok", 1'b1);

        // Check 4: accepted IDLE followed by ERROR, then by OKAY
        do_clr();
        drive(T_IDLE, 32'h0, 1'b0, 3'd0, 1'b1, 1'b1, 32'h0);
        drive(T_NONSEQ, 32'h10, 1'b0, 3'd0, 1'b1, 1'b0, 32'h0);
        idle();
        exp_p[2] = 1; exp_p[4] = 1; exp_f[4] = 1;
        check_cnts("idle_rsp", 1'b0);

        // RO write with two-cycle ERROR; write data held through the wait
        do_clr();
        drive(T_NONSEQ, 32'h2, 1'b1, 3'd0, 1'b1, 1'b0, 32'h0);
        drive(T_IDLE, 32'h0, 1'b0, 3'd0, 1'b0, 1'b1, 32'hA5A5_0001);
        drive(T_IDLE, 32'h0, 1'b0, 3'd0, 1'b1, 1'b1, 32'hA5A5_0001);
        idle();
        exp_p[1] = 1; exp_p[3] = 1;
        check_cnts("ro_err", 1'b1);

        // Out-of-range read answered OKAY
        do_clr();
        drive(T_NONSEQ, 32'h900, 1'b0, 3'd0, 1'b1, 1'b0, 32'h0);
        idle();
        check_eq("oor_pulse_hi", 32'(fail_pulse), 32'h01);
        check_eq("oor_sticky", 32'(sticky_fail), 32'h01);
        idle();
        check_eq("oor_pulse_lo", 32'(fail_pulse), 32'h00);
        check_eq("oor_sticky_hold", 32'(sticky_fail), 32'h01);
        exp_f[0] = 1;
        check_cnts("oor", 1'b1);

        // INCR4 with a BUSY after beat 2
        do_clr();
        incr4(32'h10C);
        exp_p[2] = 4; exp_p[5] = 1; exp_p[6] = 3; exp_p[7] = 4;
        check_cnts("incr4", 1'b1);

        // INCR4 with a bad 4th beat address
        do_clr();
        incr4(32'h110);
        exp_p[2] = 4; exp_p[5] = 1; exp_p[6] = 2; exp_f[6] = 1; exp_p[7] = 4;
        check_cnts("incr4_bad", 1'b1);

        // WRAP8 from 0x118, full length
        do_clr();
        drive(T_NONSEQ, wrap_seq[0], 1'b0, 3'd4, 1'b1, 1'b0, 32'h0);
        for (int b = 1; b < 8; b++) drive(T_SEQ, wrap_seq[b], 1'b0, 3'd4, 1'b1, 1'b0, 32'h0);
        idle();
        check_eq("wrap8_fsm_idle", 32'(burst_state_dbg), 32'd0);
        exp_p[2] = 8; exp_p[5] = 1; exp_p[6] = 7; exp_p[7] = 7;
        check_cnts("wrap8", 1'b1);

        // WRAP8 cut short by a NONSEQ after beat 5
        do_clr();
        drive(T_NONSEQ, wrap_seq[0], 1'b0, 3'd4, 1'b1, 1'b0, 32'h0);
        for (int b = 1; b < 5; b++) drive(T_SEQ, wrap_seq[b], 1'b0, 3'd4, 1'b1, 1'b0, 32'h0);
        drive(T_NONSEQ, 32'h200, 1'b0, 3'd0, 1'b1, 1'b0, 32'h0);
        idle();
        exp_p[2] = 6; exp_f[5] = 1; exp_p[6] = 4; exp_p[7] = 4;
        check_cnts("wrap8_short", 1'b1);

        // Address moves during a 3-cycle stall
        do_clr();
        drive(T_NONSEQ, 32'h40, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
        drive(T_NONSEQ, 32'h40, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
        drive(T_NONSEQ, 32'h44, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
        drive(T_NONSEQ, 32'h44, 1'b0, 3'd0, 1'b1, 1'b0, 32'h0);
        idle();
        exp_p[2] = 1; exp_p[3] = 2; exp_f[3] = 1;
        check_cnts("stall_addr", 1'b1);

        // Write data changes during a stalled write data phase
        do_clr();
        drive(T_NONSEQ, 32'h20, 1'b1, 3'd0, 1'b1, 1'b0, 32'h0);
        drive(T_IDLE, 32'h0, 1'b0, 3'd0, 1'b0, 1'b0, 32'h1234_5678);
        drive(T_IDLE, 32'h0, 1'b0, 3'd0, 1'b1, 1'b0, 32'h8765_4321);
        exp_p[2] = 1; exp_f[3] = 1;
        check_cnts("stall_wdata", 1'b1);

        // clr wins over a same-cycle SEQ_START violation
        clr = 1'b1;
        drive(T_SEQ, 32'h30, 1'b0, 3'd0, 1'b1, 1'b0, 32'h0);
        clr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_p[i] = 0;
            exp_f[i] = 0;
        end
        check_cnts("clr_wins", 1'b0);
        check_eq("clr_sticky", 32'(sticky_fail), 32'd0);
        idle();
        idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
